// File: rtl/wb_dma_copy_if.sv
// Bus bundle for wb_dma_copy: register-access Wishbone responder plus copy-engine Wishbone initiator.
// The DMA block uses modport 'master'; the crossbar or testbench side uses modport 'slave'.
interface wb_dma_copy_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_ack_o;

  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
    output wbs_dat_o, wbs_ack_o,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
    input  wbs_dat_o, wbs_ack_o,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wb_dma_copy.sv
// Wishbone word-copy DMA: four control registers on a responder port, and an initiator
// that alternates single-word reads and writes until the count runs out or a transfer fails.
module wb_dma_copy #(
  parameter logic [31:0] BASE_ADDR = 32'h1002_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFF0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  wb_dma_copy_if.master bus,
  output logic          irq_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [31:0] src_reg, dst_reg;
  logic [15:0] len_reg;
  logic        busy, done, err, start_req;
  logic        ack_q;
  logic [31:0] rdata_q, rmux;

  logic        slv_req, hit, reg_wr, ctrl_wr, start_set;
  logic [1:0]  reg_sel;
  logic        unused_sel;

  state_t      state, state_nx;
  logic [31:0] src_w, src_w_nx, dst_w, dst_w_nx;
  logic [15:0] cnt, cnt_nx, tcnt, tcnt_nx;
  logic [31:0] data_q, data_nx, adr_q, adr_nx;
  logic        cyc_q, cyc_nx, we_q, we_nx;
  logic        busy_nx, done_nx, err_nx, irq_q, irq_nx;

  assign unused_sel = ^bus.wbs_sel_i;

  // The ack register blocks a second request in the cycle right after an ack
  assign slv_req   = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign hit       = (bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign reg_sel   = bus.wbs_adr_i[3:2];
  assign reg_wr    = slv_req & bus.wbs_we_i & hit;
  assign ctrl_wr   = reg_wr & (reg_sel == 2'd3);
  assign start_set = ctrl_wr & bus.wbs_dat_i[0] & ~busy & ~start_req;

  always_comb begin
    rmux = 32'h0;
    case (reg_sel)
      2'd0:    rmux = src_reg;
      2'd1:    rmux = dst_reg;
      2'd2:    rmux = {16'h0, len_reg};
      default: rmux = {29'h0, err, done, busy};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
      src_reg   <= 32'h0;
      dst_reg   <= 32'h0;
      len_reg   <= 16'h0;
      start_req <= 1'b0;
    end else begin
      ack_q     <= slv_req;
      rdata_q   <= (slv_req && !bus.wbs_we_i && hit) ? rmux : 32'h0;
      start_req <= start_set;
      if (reg_wr && !busy) begin
        case (reg_sel)
          2'd0:    src_reg <= {bus.wbs_dat_i[31:2], 2'b00};
          2'd1:    dst_reg <= {bus.wbs_dat_i[31:2], 2'b00};
          2'd2:    len_reg <= bus.wbs_dat_i[15:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state  <= IDLE;
      src_w  <= 32'h0;
      dst_w  <= 32'h0;
      cnt    <= 16'h0;
      tcnt   <= 16'h0;
      data_q <= 32'h0;
      adr_q  <= 32'h0;
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      src_w  <= src_w_nx;
      dst_w  <= dst_w_nx;
      cnt    <= cnt_nx;
      tcnt   <= tcnt_nx;
      data_q <= data_nx;
      adr_q  <= adr_nx;
      cyc_q  <= cyc_nx;
      we_q   <= we_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      err    <= err_nx;
      irq_q  <= irq_nx;
    end
  end

  // In RD/WR the first cycle has cyc low: it is both the inter-transaction gap and
  // the cycle in which the address/direction for the coming strobe are registered.
  always_comb begin
    state_nx = state;
    src_w_nx = src_w;
    dst_w_nx = dst_w;
    cnt_nx   = cnt;
    tcnt_nx  = tcnt;
    data_nx  = data_q;
    adr_nx   = adr_q;
    cyc_nx   = cyc_q;
    we_nx    = we_q;
    busy_nx  = busy;
    done_nx  = done;
    err_nx   = err;
    irq_nx   = 1'b0;
    if (ctrl_wr && bus.wbs_dat_i[1]) done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          src_w_nx = src_reg;
          dst_w_nx = dst_reg;
          cnt_nx   = len_reg;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          state_nx = (len_reg == 16'h0) ? FIN : RD;
        end
      end
      RD, WR: begin
        if (!cyc_q) begin
          cyc_nx  = 1'b1;
          we_nx   = (state == WR);
          adr_nx  = (state == WR) ? dst_w : src_w;
          tcnt_nx = 16'h0;
        end else if (bus.wbm_err_i) begin
          cyc_nx   = 1'b0;
          we_nx    = 1'b0;
          err_nx   = 1'b1;
          state_nx = FIN;
        end else if (bus.wbm_ack_i) begin
          cyc_nx = 1'b0;
          we_nx  = 1'b0;
          if (state == RD) begin
            data_nx  = bus.wbm_dat_i;
            state_nx = WR;
          end else begin
            src_w_nx = src_w + 32'd4;
            dst_w_nx = dst_w + 32'd4;
            cnt_nx   = cnt - 16'd1;
            state_nx = (cnt == 16'd1) ? FIN : RD;
          end
        end else if (tcnt == TO_LAST) begin
          cyc_nx   = 1'b0;
          we_nx    = 1'b0;
          err_nx   = 1'b1;
          state_nx = FIN;
        end else begin
          tcnt_nx = tcnt + 16'd1;
        end
      end
      FIN: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        irq_nx   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdata_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = data_q;
  assign bus.wbm_sel_o = 4'hF;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy: register vector table plus copy, error, timeout,
// start-while-busy and mid-copy reset sequences against a 1-cycle-latency memory model.
module tb_wb_dma_copy;

  localparam logic [31:0] BASE = 32'h1002_0000;
  localparam logic [31:0] A_SRC = BASE + 32'h0;
  localparam logic [31:0] A_DST = BASE + 32'h4;
  localparam logic [31:0] A_LEN = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  typedef struct packed {
    logic        do_wr;
    logic [31:0] wadr;
    logic [31:0] wdat;
    logic [31:0] radr;
    logic [31:0] exp;
  } reg_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  logic clear_cnt = 1'b0;
  logic no_ack = 1'b0;
  int   err_on_read = 0;
  int   rd_cnt, wr_cnt, irq_cycles, stb_cycles;
  logic [31:0] wlog_adr [16];
  logic [31:0] wlog_dat [16];
  int   n_checks = 0;
  int   n_fail = 0;

  wb_dma_copy_if bus();

  wb_dma_copy #(.TIMEOUT(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus.master),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (a[31:4] == 28'h0001000) return 32'h1111_1111 * ({30'h0, a[3:2]} + 32'd1);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model answering the DMA initiator with a registered one-cycle ack
  always @(posedge clk) begin
    bus.wbm_ack_i <= 1'b0;
    bus.wbm_err_i <= 1'b0;
    if (clear_cnt) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else if (rst_n && bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i &&
                 !bus.wbm_err_i && !no_ack) begin
      if (bus.wbm_we_o) begin
        if (wr_cnt < 16) begin
          wlog_adr[wr_cnt] <= bus.wbm_adr_o;
          wlog_dat[wr_cnt] <= bus.wbm_dat_o;
        end
        wr_cnt <= wr_cnt + 1;
        bus.wbm_ack_i <= 1'b1;
      end else begin
        rd_cnt <= rd_cnt + 1;
        if (err_on_read != 0 && rd_cnt + 1 == err_on_read) bus.wbm_err_i <= 1'b1;
        else begin
          bus.wbm_ack_i <= 1'b1;
          bus.wbm_dat_i <= src_word(bus.wbm_adr_o);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (clear_cnt) begin
      irq_cycles <= 0;
      stb_cycles <= 0;
    end else begin
      if (irq) irq_cycles <= irq_cycles + 1;
      if (bus.wbm_stb_o) stb_cycles <= stb_cycles + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_slave_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wbs_ack_o && n < 4);
    checkOutput("slave_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bus.wbs_adr_i = a;
    bus.wbs_dat_i = d;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    wait_slave_ack();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bus.wbs_adr_i = a;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    wait_slave_ack();
    d = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    checkOutput(name, d, exp);
  endtask

  task automatic applyStimulus(input reg_vec_t v, input string name);
    if (v.do_wr) wb_write(v.wadr, v.wdat);
    read_check(name, v.radr, v.exp);
  endtask

  task automatic clear_counters();
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!irq && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(name, {31'h0, irq}, 32'h1);
  endtask

  task automatic program_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    wb_write(A_SRC, s);
    wb_write(A_DST, d);
    wb_write(A_LEN, n);
    clear_counters();
    wb_write(A_CTRL, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reg_vec_t vecs[7];
    int cyc_n;
    logic seen;

    vecs[0] = '{1'b1, A_SRC, 32'h0001_0003, A_SRC, 32'h0001_0000};
    vecs[1] = '{1'b1, A_DST, 32'h0000_8002, A_DST, 32'h0000_8000};
    vecs[2] = '{1'b1, A_LEN, 32'hABCD_1234, A_LEN, 32'h0000_1234};
    vecs[3] = '{1'b1, 32'h1002_0010, 32'hFFFF_FFFF, A_SRC, 32'h0001_0000};
    vecs[4] = '{1'b0, 32'h0, 32'h0, 32'h1003_0004, 32'h0000_0000};
    vecs[5] = '{1'b1, A_CTRL, 32'h0000_0002, A_CTRL, 32'h0000_0000};
    vecs[6] = '{1'b1, A_SRC, 32'hFFFF_FFFF, A_SRC, 32'hFFFF_FFFC};

    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    clear_counters();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    checkOutput("rst_stb", {31'h0, bus.wbm_stb_o}, 32'h0);
    checkOutput("rst_we", {31'h0, bus.wbm_we_o}, 32'h0);
    checkOutput("rst_adr", bus.wbm_adr_o, 32'h0);
    checkOutput("rst_mdat", bus.wbm_dat_o, 32'h0);
    checkOutput("rst_sel", {28'h0, bus.wbm_sel_o}, 32'hF);
    checkOutput("rst_sack", {31'h0, bus.wbs_ack_o}, 32'h0);
    checkOutput("rst_sdat", bus.wbs_dat_o, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    read_check("rst_src", A_SRC, 32'h0);
    read_check("rst_dst", A_DST, 32'h0);
    read_check("rst_len", A_LEN, 32'h0);
    read_check("rst_ctrl", A_CTRL, 32'h0);

    $display("[TB] register vectors");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("reg_vec%0d", i));

    $display("[TB] 4-word copy");
    program_copy(32'h0001_0000, 32'h0000_8000, 32'd4);
    @(negedge clk);
    checkOutput("start_lat_c1", {31'h0, bus.wbm_stb_o}, 32'h0);
    @(negedge clk);
    checkOutput("start_lat_c2", {31'h0, bus.wbm_stb_o}, 32'h1);
    checkOutput("first_rd_adr", bus.wbm_adr_o, 32'h0001_0000);
    checkOutput("first_rd_we", {31'h0, bus.wbm_we_o}, 32'h0);
    wait_irq("copy4_irq", 200, cyc_n);
    checkOutput("copy4_cycles", cyc_n, 32'd24);
    repeat (3) @(negedge clk);
    checkOutput("copy4_irq_cnt", irq_cycles, 32'd1);
    checkOutput("copy4_rd_cnt", rd_cnt, 32'd4);
    checkOutput("copy4_wr_cnt", wr_cnt, 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("copy4_wadr%0d", i), wlog_adr[i], 32'h0000_8000 + 32'(4 * i));
      checkOutput($sformatf("copy4_wdat%0d", i), wlog_dat[i], 32'h1111_1111 * 32'(i + 1));
    end
    read_check("copy4_ctrl", A_CTRL, 32'h2);

    $display("[TB] zero length");
    program_copy(32'h0001_0000, 32'h0000_8000, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    checkOutput("len0_irq", {31'h0, seen}, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("len0_xfers", rd_cnt + wr_cnt, 32'd0);
    checkOutput("len0_irq_cnt", irq_cycles, 32'd1);
    read_check("len0_ctrl", A_CTRL, 32'h2);

    $display("[TB] bus error on second read");
    err_on_read = 2;
    program_copy(32'h0001_0000, 32'h0000_8000, 32'd3);
    wait_irq("err_irq", 200, cyc_n);
    repeat (3) @(negedge clk);
    err_on_read = 0;
    checkOutput("err_wr_cnt", wr_cnt, 32'd1);
    checkOutput("err_rd_cnt", rd_cnt, 32'd2);
    read_check("err_ctrl", A_CTRL, 32'h6);

    $display("[TB] timeout");
    no_ack = 1'b1;
    program_copy(32'h0001_0000, 32'h0000_8000, 32'd1);
    wait_irq("tmo_irq", 200, cyc_n);
    repeat (3) @(negedge clk);
    no_ack = 1'b0;
    checkOutput("tmo_stb_cycles", stb_cycles, 32'd16);
    checkOutput("tmo_wr_cnt", wr_cnt, 32'd0);
    checkOutput("tmo_cyc_low", {31'h0, bus.wbm_cyc_o}, 32'h0);
    read_check("tmo_ctrl", A_CTRL, 32'h6);

    $display("[TB] start while busy");
    program_copy(32'h0001_0000, 32'h0000_8000, 32'd4);
    cyc_n = 0;
    while (wr_cnt < 1 && cyc_n < 200) begin
      @(negedge clk);
      cyc_n++;
    end
    checkOutput("busy_reach_w1", {31'h0, wr_cnt >= 1}, 32'h1);
    wb_write(A_SRC, 32'hDEAD_0000);
    wb_write(A_CTRL, 32'h1);
    read_check("busy_src", A_SRC, 32'h0001_0000);
    read_check("busy_ctrl", A_CTRL, 32'h1);
    wait_irq("busy_irq", 200, cyc_n);
    repeat (30) @(negedge clk);
    checkOutput("busy_irq_cnt", irq_cycles, 32'd1);
    checkOutput("busy_wr_cnt", wr_cnt, 32'd4);
    checkOutput("busy_rd_cnt", rd_cnt, 32'd4);
    checkOutput("busy_wdat3", wlog_dat[3], 32'h4444_4444);
    read_check("busy_done_ctrl", A_CTRL, 32'h2);

    $display("[TB] reset mid-copy");
    program_copy(32'h0001_0000, 32'h0000_8000, 32'd4);
    cyc_n = 0;
    while (wr_cnt < 2 && cyc_n < 300) begin
      @(negedge clk);
      cyc_n++;
    end
    checkOutput("mid_reach_w2", {31'h0, wr_cnt >= 2}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_async_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    checkOutput("mid_async_stb", {31'h0, bus.wbm_stb_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("mid_src", A_SRC, 32'h0);
    read_check("mid_dst", A_DST, 32'h0);
    read_check("mid_len", A_LEN, 32'h0);
    read_check("mid_ctrl", A_CTRL, 32'h0);
    repeat (60) @(negedge clk);
    checkOutput("mid_wr_cnt", wr_cnt, 32'd2);
    checkOutput("mid_irq_cnt", irq_cycles, 32'd0);
    checkOutput("mid_cyc_idle", {31'h0, bus.wbm_cyc_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
